// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: OPB slave with C_NUM_REGS PPC-to-fabric data registers (optionally shadowed behind an atomic commit) plus a CTRL/status word, driving user logic on OPB_Clk
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0100E300,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100E3FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter int          C_SHADOWED    = 0,
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic                        Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_update
);
  localparam int RW = C_NUM_REGS > 1 ? $clog2(C_NUM_REGS) : 1;
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] off, idx, rd_data, rd_q, wd_q, merged, ctrl;
  logic [3:0] be_q;
  logic [RW-1:0] ri_q;
  logic rnw_q, data_q, ctrl_q, hit, pending, wr, unused;
  logic [31:0] out_r [C_NUM_REGS];
  logic [31:0] sh_r [C_NUM_REGS];
  assign unused = OPB_seqAddr;
  assign hit = OPB_select && OPB_ABus >= C_BASEADDR && OPB_ABus <= C_HIGHADDR;
  assign off = OPB_ABus - C_BASEADDR;
  assign idx = off >> 2;
  assign ctrl = {15'd0, C_SHADOWED != 0, 8'(C_NUM_REGS), 7'd0, pending};
  assign rd_data = idx < 32'(C_NUM_REGS) ? sh_r[idx[RW-1:0]] : idx == 32'(C_NUM_REGS) ? ctrl : 32'd0;
  assign wr = state == ACK && !rnw_q;
  assign Sl_xferAck = state == ACK && !OPB_Rst;
  assign Sl_DBus = (Sl_xferAck && rnw_q) ? rd_q : '0;
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  always_comb begin
    merged = sh_r[ri_q];
    for (int b = 0; b < 4; b++) merged[8*b+:8] = be_q[b] ? wd_q[8*b+:8] : sh_r[ri_q][8*b+:8];
  end
  always_comb begin
    state_n = state == IDLE ? (hit ? ACK : IDLE) : state == ACK ? HOLD : (OPB_select ? HOLD : IDLE);
  end
  always_ff @(posedge OPB_Clk) begin
    state <= OPB_Rst ? IDLE : state_n;
  end
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        out_r[i] <= C_RESET_VALUE;
        sh_r[i] <= C_RESET_VALUE;
      end
      pending <= 1'b0;
      user_update <= '0;
      rnw_q <= 1'b1;
      data_q <= 1'b0;
      ctrl_q <= 1'b0;
    end else begin
      user_update <= '0;
      if (state == IDLE && hit) begin
        rnw_q <= OPB_RNW;
        be_q <= OPB_BE;
        wd_q <= OPB_DBus;
        rd_q <= rd_data;
        ri_q <= idx[RW-1:0];
        data_q <= idx < 32'(C_NUM_REGS);
        ctrl_q <= idx == 32'(C_NUM_REGS);
      end
      if (wr && data_q && |be_q) begin
        sh_r[ri_q] <= merged;
        if (C_SHADOWED != 0) pending <= 1'b1;
        else begin
          out_r[ri_q] <= merged;
          user_update[ri_q] <= 1'b1;
        end
      end
      if (wr && ctrl_q && C_SHADOWED != 0 && be_q[0] && wd_q[0]) begin
        for (int i = 0; i < C_NUM_REGS; i++) out_r[i] <= sh_r[i];
        pending <= 1'b0;
        user_update <= '1;
      end
    end
  end
  generate
    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
      assign user_data_out[32*i+:32] = out_r[i];
    end
  endgenerate
endmodule
